mux_n_pipe: RTL and testbench

- Parametrised N-input, DATA_W-wide multiplexer with a registered output stage and a valid/ready handshake.
- Next generation of the combinational 2/3-input datapath muxes. Supports any input count, encoded or priority select, and back-pressure through a 2-entry skid buffer, so it can sit on pipeline-stage boundaries (e.g. forwarding/writeback select) without a combinational ready path.

---
 rtl/mux_pkg.sv | 22 ++
 rtl/mux_n_sel.sv | 45 ++++
 rtl/mux_n_pipe.sv | 133 +++++++++++++
 tb/tb_mux_n_pipe.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the N-way datapath mux family.
//   MUX_MODE_ENC / MUX_MODE_PRIO : select-mode encodings for PRIO_MODE
//   MUX_MAX_N_IN                 : largest supported input count
//   pipe_state_e                 : skid-buffer state, encoded as {out_valid, skid_valid}
//   sel_width()                  : select port width for a given input count and mode
package mux_pkg;

  localparam int MUX_MODE_ENC  = 0;
  localparam int MUX_MODE_PRIO = 1;
  localparam int MUX_MAX_N_IN  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } pipe_state_e;

  function automatic int sel_width(input int n_in, input int mode);
    return (mode == MUX_MODE_PRIO) ? (n_in - 1) : $clog2(n_in);
  endfunction

endpackage

// File: rtl/mux_n_sel.sv
// mux_n_sel: combinational N-way, DATA_W-wide select.
//   in_data  : packed inputs, input k at [k*DATA_W +: DATA_W]
//   in_sel   : binary index (PRIO_MODE=0) or priority vector (PRIO_MODE=1)
//   out_data : selected input; zero for an out-of-range index, input N_IN-1
//              when no priority bit is set
module mux_n_sel
  import mux_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int N_IN      = 3,
  parameter  int PRIO_MODE = MUX_MODE_ENC,
  localparam int SEL_W     = sel_width(N_IN, PRIO_MODE)
) (
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [DATA_W-1:0]      out_data
);

  if (N_IN < 2 || N_IN > MUX_MAX_N_IN) begin : g_bad_n_in
    $error("mux_n_sel: N_IN out of range");
  end

  if (PRIO_MODE == MUX_MODE_PRIO) begin : g_prio
    // Walk from the highest priority bit down so the lowest set index is
    // the last (winning) assignment.
    always_comb begin
      out_data = in_data[(N_IN-1)*DATA_W +: DATA_W];
      for (int unsigned j = 0; j < N_IN - 1; j++) begin
        if (in_sel[N_IN-2-j]) begin
          out_data = in_data[(N_IN-2-j)*DATA_W +: DATA_W];
        end
      end
    end
  end else begin : g_enc
    always_comb begin
      out_data = '0;
      for (int unsigned k = 0; k < N_IN; k++) begin
        if (32'(in_sel) == k) begin
          out_data = in_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-input mux with registered output and a 2-entry skid buffer.
//   clk, arst   : clock, asynchronous active-high reset
//   in_data     : packed inputs, input k at [k*DATA_W +: DATA_W]
//   in_sel      : select, sampled together with in_data on accept
//   in_valid    : upstream beat valid
//   in_ready    : registered, low only while both registers hold beats
//   out_data    : registered selected data
//   out_valid   : out_data holds a beat
//   out_ready   : downstream accepts
//   sel_err     : (only with MUX_N_PIPE_SEL_CHECK_EN) sticky flag, set by an
//                 accepted beat with an invalid select, cleared by arst
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int N_IN      = 3,
  parameter  int PRIO_MODE = MUX_MODE_ENC,
  localparam int SEL_W     = sel_width(N_IN, PRIO_MODE)
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef MUX_N_PIPE_SEL_CHECK_EN
  ,
  output logic                   sel_err
`endif
);

  logic [DATA_W-1:0] sel_data;
  logic              accept;
  logic              deliver;

  pipe_state_e       state_q,     state_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q,  in_ready_d;

  mux_n_sel #(
    .DATA_W    (DATA_W),
    .N_IN      (N_IN),
    .PRIO_MODE (PRIO_MODE)
  ) u_sel (
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_data (sel_data)
  );

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign accept    = in_valid && in_ready_q;
  assign deliver   = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_data_d = sel_data;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && deliver) begin
          out_data_d = sel_data;
        end else if (accept) begin
          skid_data_d = sel_data;
          state_d     = ST_FULL;
        end else if (deliver) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (deliver) begin
          out_data_d = skid_data_q;
          state_d    = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Registered copy of !skid_valid, computed from the next state so it
    // never lags the skid register.
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef MUX_N_PIPE_SEL_CHECK_EN
  logic sel_bad;
  logic sel_err_q, sel_err_d;

  if (PRIO_MODE == MUX_MODE_PRIO) begin : g_chk_prio
    assign sel_bad = ($countones(in_sel) > 1);
  end else begin : g_chk_enc
    assign sel_bad = (32'(in_sel) >= N_IN);
  end

  always_comb begin
    sel_err_d = sel_err_q | (accept & sel_bad);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: one encoded-select and one priority-select instance
// share clock, reset, data and handshake; each has its own select.
module tb_mux_n_pipe;

  logic        clk = 1'b0;
  logic        arst;
  logic [47:0] in_data;
  logic [1:0]  sel0, sel1;
  logic        in_valid, out_ready;
  logic        in_ready0, in_ready1, out_valid0, out_valid1;
  logic [15:0] out_data0, out_data1;
`ifdef MUX_N_PIPE_SEL_CHECK_EN
  logic        sel_err0, sel_err1;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: one queue of expected beats per instance, plus sticky error flags.
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        err0_m, err1_m;
  logic        prev_stall;
  logic [15:0] prev_d0, prev_d1;

  always #5 clk = ~clk;

  mux_n_pipe #(.DATA_W(16), .N_IN(3), .PRIO_MODE(0)) dut_enc (
    .clk(clk), .arst(arst), .in_data(in_data), .in_sel(sel0),
    .in_valid(in_valid), .in_ready(in_ready0), .out_data(out_data0),
    .out_valid(out_valid0), .out_ready(out_ready)
`ifdef MUX_N_PIPE_SEL_CHECK_EN
    , .sel_err(sel_err0)
`endif
  );

  mux_n_pipe #(.DATA_W(16), .N_IN(3), .PRIO_MODE(1)) dut_prio (
    .clk(clk), .arst(arst), .in_data(in_data), .in_sel(sel1),
    .in_valid(in_valid), .in_ready(in_ready1), .out_data(out_data1),
    .out_valid(out_valid1), .out_ready(out_ready)
`ifdef MUX_N_PIPE_SEL_CHECK_EN
    , .sel_err(sel_err1)
`endif
  );

  function automatic logic [15:0] ref_enc(input logic [47:0] d, input logic [1:0] s);
    if (s < 2'd3) return 16'(d >> (16 * s));
    return 16'h0000;
  endfunction

  function automatic logic [15:0] ref_prio(input logic [47:0] d, input logic [1:0] s);
    for (int unsigned i = 0; i < 2; i++) begin
      if (s[i]) return 16'(d >> (16 * i));
    end
    return d[47:32];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready_enc",  {31'd0, in_ready0},  {31'd0, q0.size() < 2});
    chk("in_ready_prio", {31'd0, in_ready1},  {31'd0, q1.size() < 2});
    chk("out_valid_enc", {31'd0, out_valid0}, {31'd0, q0.size() > 0});
    chk("out_valid_prio",{31'd0, out_valid1}, {31'd0, q1.size() > 0});
    if (q0.size() > 0) chk("out_data_enc",  {16'd0, out_data0}, {16'd0, q0[0]});
    if (q1.size() > 0) chk("out_data_prio", {16'd0, out_data1}, {16'd0, q1[0]});
    if (prev_stall) begin
      chk("stall_hold_enc",  {16'd0, out_data0}, {16'd0, prev_d0});
      chk("stall_hold_prio", {16'd0, out_data1}, {16'd0, prev_d1});
    end
`ifdef MUX_N_PIPE_SEL_CHECK_EN
    chk("sel_err_enc",  {31'd0, sel_err0}, {31'd0, err0_m});
    chk("sel_err_prio", {31'd0, sel_err1}, {31'd0, err1_m});
`endif
  endtask

  // Called just after a falling edge: drive, take one rising edge, update model, check.
  task automatic step(input logic v, input logic r, input logic [1:0] s0,
                      input logic [1:0] s1, input logic [47:0] d);
    logic acc, del;
    in_valid  = v;
    out_ready = r;
    sel0      = s0;
    sel1      = s1;
    in_data   = d;
    acc = v && (q0.size() < 2);
    del = r && (q0.size() > 0);
    prev_stall = (q0.size() > 0) && !r;
    if (prev_stall) begin
      prev_d0 = q0[0];
      prev_d1 = q1[0];
    end
    @(posedge clk);
    if (del) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
    end
    if (acc) begin
      q0.push_back(ref_enc(d, s0));
      q1.push_back(ref_prio(d, s1));
      if (s0 >= 2'd3) err0_m = 1'b1;
      if (s1 == 2'b11) err1_m = 1'b1;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    err0_m     = 1'b0;
    err1_m     = 1'b0;
    prev_stall = 1'b0;
  endtask

  initial begin
    logic [47:0] abc;
    abc = {16'h3333, 16'h2222, 16'h1111};
    arst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sel0 = 2'd0; sel1 = 2'd0; in_data = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready0},  32'd1);
    chk("rst_out_data",  {16'd0, out_data0},  32'd0);
    chk("rst_in_ready_p",{31'd0, in_ready1},  32'd1);
    arst = 1'b0;

    // Streaming with out_ready high: one beat in flight, throughput 1/cycle
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 2'd1, 2'b10, abc);
    chk("stream_data", {16'd0, out_data0}, 32'h2222);
    step(1'b0, 1'b1, 2'd0, 2'b00, abc);

    // Back-pressure: two beats fill the buffer, third waits
    step(1'b1, 1'b0, 2'd0, 2'b11, abc);
    step(1'b1, 1'b0, 2'd1, 2'b10, abc);
    chk("bp_in_ready", {31'd0, in_ready0}, 32'd0);
    step(1'b1, 1'b0, 2'd2, 2'b00, abc);
    chk("bp_hold", {16'd0, out_data0}, 32'h1111);
    for (int i = 0; i < 5; i++) step(i < 2, 1'b1, 2'd2, 2'b00, abc);
    chk("bp_drained", {31'd0, out_valid0}, 32'd0);

    // Out-of-range encoded select and multi-bit priority select
    step(1'b1, 1'b1, 2'd3, 2'b11, abc);
    chk("oor_zero", {16'd0, out_data0}, 32'h0000);
    chk("prio_11",  {16'd0, out_data1}, 32'h1111);
    step(1'b1, 1'b1, 2'd0, 2'b00, abc);
    chk("prio_00",  {16'd0, out_data1}, 32'h3333);
    step(1'b0, 1'b1, 2'd0, 2'b00, abc);

    // Reset asserted between edges while FULL
    step(1'b1, 1'b0, 2'd0, 2'b01, abc);
    step(1'b1, 1'b0, 2'd2, 2'b10, abc);
    chk("full_in_ready", {31'd0, in_ready0}, 32'd0);
    @(posedge clk);
    #2 arst = 1'b1;
    #1;
    model_reset();
    chk("midrst_out_valid", {31'd0, out_valid0}, 32'd0);
    chk("midrst_in_ready",  {31'd0, in_ready0},  32'd1);
    chk("midrst_valid_p",   {31'd0, out_valid1}, 32'd0);
    @(negedge clk);
    arst = 1'b0;
    step(1'b0, 1'b1, 2'd0, 2'b00, abc);
    step(1'b0, 1'b1, 2'd0, 2'b00, abc);
    step(1'b1, 1'b1, 2'd2, 2'b00, abc);

    // Random soak
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           2'($urandom), 2'($urandom), {$urandom, 16'($urandom)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
